// File: rtl/nco_phase_acc.sv
// -----------------------------------------------------------------------------
// nco_phase_acc
//
// Phase-generation stage that feeds cordic_nco. A frequency tuning word (FTW)
// and a phase offset are loaded byte-serially, least significant byte first,
// into a shadow register. Once all bytes of a word are in, the word is copied
// to the live register in a single COMMIT cycle, so the accumulator never sees
// a half-written value. The phase accumulator advances by FTW on every clock
// enable. The registered output is accumulator + offset.
//
// Optional feature (compile-time macro NCO_DITHER_EN):
//   When the macro is defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11,
//   seed 16'hACE1) adds a 4-bit dither to the output phase. The LFSR steps on
//   each i_ce, and i_sync reseeds it. When the macro is undefined, no LFSR
//   logic is built.
//
// Parameters:
//   PW  phase / accumulator / FTW width; must be a multiple of BW
//   BW  load bus width
//   NB  bytes per load word (PW/BW, derived); must be at least 2
//
// Ports:
//   i_clk     clock, rising edge
//   i_reset   asynchronous active-high reset
//   i_ce      clock enable for the accumulator and the output phase
//   i_wr      byte write strobe, one byte per cycle while high
//   i_sel     load target: 0 = FTW, 1 = phase offset
//   i_data    write byte
//   i_sync    synchronous accumulator clear, independent of i_ce
//   o_phase   registered phase word to cordic_nco
//   o_busy    high while a partial multi-byte load is pending
//   o_commit  one-cycle pulse during the cycle the shadow word is copied
// -----------------------------------------------------------------------------
module nco_phase_acc #(
  parameter int PW = 24,
  parameter int BW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_wr,
  input  logic          i_sel,
  input  logic [BW-1:0] i_data,
  input  logic          i_sync,
  output logic [PW-1:0] o_phase,
  output logic          o_busy,
  output logic          o_commit
);

  localparam int NB = PW / BW;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Modulo-2^PW phase addition; the carry out is dropped on purpose so the
  // accumulator wraps silently.
  function automatic logic [PW-1:0] phase_add(input logic [PW-1:0] a,
                                              input logic [PW-1:0] b);
    logic [PW:0] full;
    full = {1'b0, a} + {1'b0, b};
    return full[PW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // Loader state
  // ---------------------------------------------------------------------------
  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          tgt_q;
  logic [PW-1:0] shadow_q;
  logic          busy_q;
  logic          commit_q;

  logic [PW-1:0] ftw_q;
  logic [PW-1:0] poff_q;

  // start_load: this byte begins a new word. That happens from IDLE, from
  // COMMIT (back-to-back words), or when the target changes mid-load. In the
  // last case the partial shadow is abandoned.
  logic start_load;
  logic byte_wr;
  logic last_byte;

  always_comb begin
    start_load = 1'b0;
    byte_wr    = 1'b0;
    last_byte  = 1'b0;
    if (i_wr) begin
      case (state_q)
        IDLE:    start_load = 1'b1;
        COMMIT:  start_load = 1'b1;
        LOAD: begin
          if (i_sel != tgt_q) begin
            start_load = 1'b1;
          end else begin
            byte_wr   = 1'b1;
            last_byte = (cnt_q == CW'(NB - 1));
          end
        end
        default: start_load = 1'b0;
      endcase
    end
  end

  // Loader FSM with registered busy/commit outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tgt_q    <= 1'b0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      commit_q <= 1'b0;
      if (start_load) begin
        state_q <= LOAD;
        tgt_q   <= i_sel;
        cnt_q   <= CW'(1);
        busy_q  <= 1'b1;
      end else if (last_byte) begin
        state_q  <= COMMIT;
        busy_q   <= 1'b0;
        commit_q <= 1'b1;
      end else if (byte_wr) begin
        cnt_q <= cnt_q + CW'(1);
      end else if (state_q == COMMIT) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  // Shadow register: a fresh word clears the upper bytes so an abandoned
  // partial load can never leak into the next word.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      shadow_q <= '0;
    end else if (start_load) begin
      shadow_q <= {{(PW - BW){1'b0}}, i_data};
    end else if (byte_wr) begin
      shadow_q[cnt_q*BW +: BW] <= i_data;
    end
  end

  // Live tuning registers, updated on the edge that ends the COMMIT cycle.
  // The copy reads the pre-edge target, so a new word that starts in the
  // same cycle does not redirect it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ftw_q  <= '0;
      poff_q <= '0;
    end else if (state_q == COMMIT) begin
      if (tgt_q) begin
        poff_q <= shadow_q;
      end else begin
        ftw_q <= shadow_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Phase datapath
  // ---------------------------------------------------------------------------
  logic [PW-1:0] acc_q;
  logic [PW-1:0] acc_d;
  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  always_comb begin
    acc_d = acc_q;
    if (i_sync) begin
      acc_d = '0;
    end else if (i_ce) begin
      acc_d = phase_add(acc_q, ftw_q);
    end
  end

`ifdef NCO_DITHER_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  // Right-shifting Fibonacci form: taps 16,14,13,11 map to bits 0,2,3,5.
  assign lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (i_sync) begin
      lfsr_q <= LFSR_SEED;
    end else if (i_ce) begin
      lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
    end
  end

  // The dither is the current (pre-step) low nibble.
  always_comb begin
    phase_d = phase_add(phase_add(acc_d, poff_q), {{(PW - 4){1'b0}}, lfsr_q[3:0]});
  end
`else
  always_comb begin
    phase_d = phase_add(acc_d, poff_q);
  end
`endif

  // Accumulator and output register: the output follows the value the
  // accumulator takes on this same edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_q   <= '0;
      phase_q <= '0;
    end else begin
      acc_q <= acc_d;
      if (i_ce || i_sync) begin
        phase_q <= phase_d;
      end
    end
  end

  assign o_phase  = phase_q;
  assign o_busy   = busy_q;
  assign o_commit = commit_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
module tb_nco_phase_acc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, wr = 1'b0, sel = 1'b0, sync = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [23:0] o_phase;
  logic        o_busy, o_commit;

  int pass_cnt = 0;
  int total_cnt = 0;

  nco_phase_acc #(.PW(24), .BW(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .i_ce    (ce),
    .i_wr    (wr),
    .i_sel   (sel),
    .i_data  (data),
    .i_sync  (sync),
    .o_phase (o_phase),
    .o_busy  (o_busy),
    .o_commit(o_commit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ce, wr, sel, sync;
    logic [7:0]  data;
    logic [23:0] phase;
    logic        busy, commit;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic c, input logic w, input logic s, input logic y,
                              input logic [7:0] d, input logic [23:0] ph,
                              input logic b, input logic cm);
    vec_t v;
    v.ce = c; v.wr = w; v.sel = s; v.sync = y; v.data = d;
    v.phase = ph; v.busy = b; v.commit = cm;
    return v;
  endfunction

  task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic c, input logic w, input logic s, input logic y,
                      input logic [7:0] d);
    ce = c; wr = w; sel = s; sync = y; data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [23:0] ph,
                         input logic b, input logic cm);
    chk({tag, ".phase"},  o_phase, ph);
    chk({tag, ".busy"},   24'(o_busy), 24'(b));
    chk({tag, ".commit"}, 24'(o_commit), 24'(cm));
  endtask

  initial begin
    // FTW = 0x000010, back-to-back bytes with ce high
    vq.push_back(mk(1,1,0,0,8'h10, 24'h000000,1,0));
    vq.push_back(mk(1,1,0,0,8'h00, 24'h000000,1,0));
    vq.push_back(mk(1,1,0,0,8'h00, 24'h000000,0,1));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000000,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000010,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000020,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000030,0,0));
    // FTW = 0x800000 loaded with ce low, then sync and wrap
    vq.push_back(mk(0,1,0,0,8'h00, 24'h000030,1,0));
    vq.push_back(mk(0,1,0,0,8'h00, 24'h000030,1,0));
    vq.push_back(mk(0,1,0,0,8'h80, 24'h000030,0,1));
    vq.push_back(mk(0,0,0,0,8'h00, 24'h000030,0,0));
    vq.push_back(mk(0,0,0,1,8'h00, 24'h000000,0,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(1,0,0,0,8'h00, (i % 2 == 0) ? 24'h800000 : 24'h000000,0,0));
    for (int i = 0; i < 5; i++)
      vq.push_back(mk(0,0,0,0,8'h00, 24'h800000,0,0));
    // FTW = 1, then poff 0x400000 loaded while running
    vq.push_back(mk(0,1,0,0,8'h01, 24'h800000,1,0));
    vq.push_back(mk(0,1,0,0,8'h00, 24'h800000,1,0));
    vq.push_back(mk(0,1,0,0,8'h00, 24'h800000,0,1));
    vq.push_back(mk(0,0,0,0,8'h00, 24'h800000,0,0));
    vq.push_back(mk(0,0,0,1,8'h00, 24'h000000,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000001,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000002,0,0));
    vq.push_back(mk(1,1,1,0,8'h00, 24'h000003,1,0));
    vq.push_back(mk(1,1,1,0,8'h00, 24'h000004,1,0));
    vq.push_back(mk(1,1,1,0,8'h40, 24'h000005,0,1));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000006,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h400007,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h400008,0,0));
    // Two FTW bytes abandoned by a target change; poff = 5
    vq.push_back(mk(0,1,0,0,8'hAA, 24'h400008,1,0));
    vq.push_back(mk(0,1,0,0,8'hBB, 24'h400008,1,0));
    vq.push_back(mk(0,1,1,0,8'h05, 24'h400008,1,0));
    vq.push_back(mk(0,1,1,0,8'h00, 24'h400008,1,0));
    vq.push_back(mk(0,1,1,0,8'h00, 24'h400008,0,1));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h400009,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h00000F,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000010,0,0));
    // FTW = 0x123456, sync, one step -> acc = 0x123456
    vq.push_back(mk(0,1,0,0,8'h56, 24'h000010,1,0));
    vq.push_back(mk(0,1,0,0,8'h34, 24'h000010,1,0));
    vq.push_back(mk(0,1,0,0,8'h12, 24'h000010,0,1));
    vq.push_back(mk(0,0,0,1,8'h00, 24'h000005,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h12345B,0,0));
    // FTW = 0x000100 committed in the same cycle as sync
    vq.push_back(mk(0,1,0,0,8'h00, 24'h12345B,1,0));
    vq.push_back(mk(0,1,0,0,8'h01, 24'h12345B,1,0));
    vq.push_back(mk(0,1,0,0,8'h00, 24'h12345B,0,1));
    vq.push_back(mk(0,0,0,1,8'h00, 24'h000005,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000105,0,0));
    // poff = 0, then poff = 7 started during the COMMIT cycle
    vq.push_back(mk(0,1,1,0,8'h00, 24'h000105,1,0));
    vq.push_back(mk(0,1,1,0,8'h00, 24'h000105,1,0));
    vq.push_back(mk(0,1,1,0,8'h00, 24'h000105,0,1));
    vq.push_back(mk(0,1,1,0,8'h07, 24'h000105,1,0));
    vq.push_back(mk(0,1,1,0,8'h00, 24'h000105,1,0));
    vq.push_back(mk(0,1,1,0,8'h00, 24'h000105,0,1));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000200,0,0));
    vq.push_back(mk(1,0,0,0,8'h00, 24'h000307,0,0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 24'h000000, 1'b0, 1'b0);
    rst = 1'b0;

    foreach (vq[i]) begin
      step(vq[i].ce, vq[i].wr, vq[i].sel, vq[i].sync, vq[i].data);
      chk_out($sformatf("v%0d", i), vq[i].phase, vq[i].busy, vq[i].commit);
    end

    // Asynchronous reset in the middle of a load
    step(0, 1, 0, 0, 8'h11);
    chk_out("midload", 24'h000307, 1'b1, 1'b0);
    wr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 24'h000000, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 8'h00);
    chk_out("post_rst0", 24'h000000, 1'b0, 1'b0);
    step(1, 0, 0, 0, 8'h00);
    chk_out("post_rst1", 24'h000000, 1'b0, 1'b0);
    // A fresh load after reset must need all three bytes
    step(0, 1, 0, 0, 8'h22);
    chk_out("reload0", 24'h000000, 1'b1, 1'b0);
    step(0, 1, 0, 0, 8'h00);
    chk_out("reload1", 24'h000000, 1'b1, 1'b0);
    step(0, 1, 0, 0, 8'h00);
    chk_out("reload2", 24'h000000, 1'b0, 1'b1);
    step(1, 0, 0, 0, 8'h00);
    chk_out("reload3", 24'h000000, 1'b0, 1'b0);
    step(1, 0, 0, 0, 8'h00);
    chk_out("reload4", 24'h000022, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/nco_phase_acc.md
Name: nco_phase_acc

Overview:
- Phase-generation stage directly upstream of cordic_nco; produces the 24-bit i_phase word the CORDIC rotator consumes.
- Frequency tuning word (FTW) and phase offset are loaded byte-serially over the 8-bit pin bus, LSB first.
- Loaded values commit atomically to a phase accumulator.
- Output is a registered phase (accumulator + offset) advancing once per clock-enable.

Parameters:
- PW, 24, phase / accumulator / FTW width in bits; must be a multiple of BW.
- BW, 8, load bus width in bits.
- NB, PW/BW (3), bytes per load word; derived, not overridable.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_ce  input  1  clock enable; accumulator and output advance only when high.
- i_wr  input  1  byte write strobe; one byte accepted per cycle high.
- i_sel  input  1  load target: 0 = FTW, 1 = phase offset.
- i_data  input  BW  write byte.
- i_sync  input  1  synchronous accumulator clear; independent of i_ce.
- o_phase  output  PW  registered phase to cordic_nco.
- o_busy  output  1  high while a partial multi-byte load is pending.
- o_commit  output  1  one-cycle pulse on the cycle the shadow value becomes active.

Behaviour:
- Reset (async assert): acc, ftw, poff, shadow, byte count and o_phase go to 0; o_busy=0, o_commit=0; FSM to IDLE. Release takes effect on the next rising edge.
- Loader FSM states: IDLE, LOAD (byte count 1..NB-1), COMMIT.
- IDLE:
  - i_wr → shadow[BW-1:0]=i_data, latch i_sel as target, cnt=1, go to LOAD.
- LOAD:
  - i_wr with i_sel==target → write byte cnt into shadow, cnt++.
  - After byte NB-1 is written, go to COMMIT.
- COMMIT, one cycle:
  - Copy shadow to ftw or poff per target.
  - o_commit=1.
  - Return to IDLE.
  - i_wr in this cycle is a new byte 0; the FSM moves to LOAD directly.
- Target change mid-load: i_wr with i_sel≠target in LOAD discards the partial shadow and restarts with this byte as byte 0 of the new target.
- Idle gaps between bytes are allowed; there is no timeout.
- o_busy = (state==LOAD).
- Accumulator:
  - If i_sync, acc<=0.
  - Else if i_ce, acc<=acc+ftw, modulo 2^PW; wrap is silent.
- Output: if i_ce or i_sync, o_phase<=acc_next+poff (mod 2^PW), where acc_next is the value acc takes this edge. Latency: one cycle from the acc update.
- Commit timing: the new ftw is first used on the i_ce cycle after the COMMIT cycle. The new poff appears on o_phase at the first i_ce edge after COMMIT.
- Simultaneous i_sync and COMMIT: acc clears, and the new ftw takes effect on the next cycle. o_phase = 0 + old poff if poff is the target, and it updates on the following i_ce.
- Loads proceed while i_ce=0; only acc/o_phase are gated.
- Reset asserted mid-load: the partial shadow is lost; nothing commits.

Optional Feature:
- Macro: NCO_DITHER_EN.
- Defined:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, seed 16'hACE1 on reset.
  - Steps on each i_ce.
  - LFSR[3:0] is zero-extended and added to acc_next+poff before o_phase is registered, to break spur periodicity.
  - i_sync also reseeds the LFSR.
- Undefined: no LFSR logic; o_phase exactly as above.
- Test bench checks run with the macro undefined unless stated.

Test Plan:
- Reset, then i_wr bytes 8'h10,8'h00,8'h00, i_sel=0, i_ce=1 → o_commit pulses one cycle after third byte; o_phase sequence 0x000010, 0x000020, 0x000030…
- FTW=0x800000, i_ce=1 → o_phase alternates 0x800000, 0x000000 (wrap check); i_ce held low 5 cycles → o_phase frozen.
- FTW=0x000001, load poff bytes 0x00,0x00,0x40 → o_phase jumps by +0x400000 at first i_ce after commit; accumulator continuity preserved.
- Write 2 FTW bytes, then i_wr with i_sel=1 bytes 0x05,0x00,0x00 → FTW unchanged, poff=0x000005, only one o_commit pulse, o_busy high for exactly 2 cycles of the poff load.
- i_sync asserted same cycle as COMMIT of FTW=0x000100 with acc=0x123456 → acc=0; next i_ce acc=0x000100; i_reset pulsed mid-load → o_busy=0, o_phase=0 immediately (async).
- With NCO_DITHER_EN, FTW=0 → o_phase = poff + LFSR[3:0]; first values after reset follow seed 16'hACE1 (low nibble 0x1 on first step before shift, per golden model).
